// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// immediate formats, ALU ops and instruction classes.
package multicycle_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned IMM_W    = 2;
    localparam int unsigned ALU_OP_W = 2;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [IMM_W-1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_sel_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [2:0] {
        IC_R       = 3'd0,
        IC_IALU    = 3'd1,
        IC_LOAD    = 3'd2,
        IC_STORE   = 3'd3,
        IC_BEQ     = 3'd4,
        IC_ILLEGAL = 3'd5
    } iclass_e;

    // Immediate format implied by an instruction class.
    function automatic imm_sel_e imm_sel_of(input iclass_e cls);
        case (cls)
            IC_IALU, IC_LOAD: imm_sel_of = IMM_I;
            IC_STORE:         imm_sel_of = IMM_S;
            IC_BEQ:           imm_sel_of = IMM_B;
            default:          imm_sel_of = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct3 decode into instruction class, immediate
// format and legality.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    output iclass_e          iclass_o,
    output logic [IMM_W-1:0] imm_sel_o,
    output logic             legal_o
);

    iclass_e cls;

    always_comb begin
        cls = IC_ILLEGAL;
        case (opcode_i)
            OPC_OP:     cls = IC_R;
            OPC_OP_IMM: cls = IC_IALU;
            OPC_LOAD:   cls = IC_LOAD;
            OPC_STORE:  cls = IC_STORE;
            OPC_BRANCH: if (funct3_i == F3_BEQ) cls = IC_BEQ;
            default:    cls = IC_ILLEGAL;
        endcase
    end

    assign iclass_o  = cls;
    assign imm_sel_o = imm_sel_of(cls);
    assign legal_o   = (cls != IC_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V subset control FSM with retired-instruction counter.
// The instruction class is latched in DECODE so later states don't depend on instr_i.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [XLEN-1:0]     instr_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                ir_we_o,
    output logic                pc_we_o,
    output logic                pc_src_o,
    output logic [IMM_W-1:0]    imm_sel_o,
    output logic                alu_src_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                reg_we_o,
    output logic                mem_to_reg_o,
    output logic [STATE_W-1:0]  state_o,
    output logic                illegal_o,
    output logic [XLEN-1:0]     instret_o
);

    state_e           state_q, state_d;
    iclass_e          iclass_q, iclass_d;
    logic [XLEN-1:0]  instret_q, instret_d;
    logic             retire_c;

    iclass_e          dec_class;
    logic [IMM_W-1:0] dec_imm_sel;
    logic             dec_legal;

    logic             unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[31:15], instr_i[11:7]};

    ctrl_decode u_decode (
        .opcode_i  (instr_i[6:0]),
        .funct3_i  (instr_i[14:12]),
        .iclass_o  (dec_class),
        .imm_sel_o (dec_imm_sel),
        .legal_o   (dec_legal)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            iclass_q  <= IC_ILLEGAL;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            iclass_q  <= iclass_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d      = state_q;
        iclass_d     = iclass_q;
        retire_c     = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 1'b0;
        imm_sel_o    = IMM_NONE;
        alu_src_o    = 1'b0;
        alu_op_o     = ALU_ADD;
        reg_we_o     = 1'b0;
        mem_to_reg_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                imm_sel_o = dec_imm_sel;
                iclass_d  = dec_class;
                state_d   = dec_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                imm_sel_o = imm_sel_of(iclass_q);
                case (iclass_q)
                    IC_R: begin
                        alu_op_o = ALU_FUNCT;
                        state_d  = ST_WB;
                    end
                    IC_IALU: begin
                        alu_src_o = 1'b1;
                        alu_op_o  = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    IC_LOAD, IC_STORE: begin
                        alu_src_o = 1'b1;
                        state_d   = ST_MEM;
                    end
                    IC_BEQ: begin
                        alu_op_o = ALU_SUB;
                        pc_we_o  = zero_i;
                        pc_src_o = 1'b1;
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (iclass_q == IC_STORE);
                if (mem_ready_i) begin
                    if (iclass_q == IC_STORE) begin
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d  = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we_o     = 1'b1;
                mem_to_reg_o = (iclass_q == IC_LOAD);
                retire_c     = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    assign instret_d = retire_c ? instret_q + XLEN'(1) : instret_q;
    assign instret_o = instret_q;
    assign state_o   = state_q;
    assign illegal_o = (state_q == ST_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic        zero;
    logic        ready;
    logic        mem_req, mem_we, ir_we, pc_we, pc_src;
    logic [1:0]  imm_sel;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        reg_we, mem_to_reg;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .instr_i      (instr),
        .zero_i       (zero),
        .mem_ready_i  (ready),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .ir_we_o      (ir_we),
        .pc_we_o      (pc_we),
        .pc_src_o     (pc_src),
        .imm_sel_o    (imm_sel),
        .alu_src_o    (alu_src),
        .alu_op_o     (alu_op),
        .reg_we_o     (reg_we),
        .mem_to_reg_o (mem_to_reg),
        .state_o      (state),
        .illegal_o    (illegal),
        .instret_o    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; ready = 1'b0; zero = 1'b0; instr = 32'h0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; ready = 1'b1; zero = 1'b0; instr = 32'h0;
        step(); step();
        checks++;
        if ({state, illegal, instret} !== {3'd0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: state=%0d illegal=%0b instret=%0d, want 0 0 0", state, illegal, instret);
        end
        checks++;
        if ({mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, mem_to_reg, imm_sel} !== 9'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0", {mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, mem_to_reg, imm_sel});
        end
        rst = 1'b1;
        step();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: state=%0d want 0 (ready without start)", state);
        end
    endtask

    task automatic test_addi();
        do_reset();
        instr = 32'h00500093; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, mem_req, mem_we, ir_we, pc_we, pc_src} !== {3'd1, 5'b10110}) begin
            errors++;
            $display("FAIL addi_fetch: state=%0d req/we/irwe/pcwe/pcsrc=%b want 1 10110", state, {mem_req, mem_we, ir_we, pc_we, pc_src});
        end
        step();
        checks++;
        if ({state, imm_sel} !== {3'd2, 2'd1}) begin
            errors++;
            $display("FAIL addi_decode: state=%0d imm_sel=%0d want 2 1", state, imm_sel);
        end
        step();
        checks++;
        if ({state, imm_sel, alu_src, alu_op, reg_we} !== {3'd3, 2'd1, 1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL addi_exec: state=%0d imm=%0d src=%0b op=%0d regwe=%0b want 3 1 1 2 0", state, imm_sel, alu_src, alu_op, reg_we);
        end
        step();
        checks++;
        if ({state, reg_we, mem_to_reg, instret} !== {3'd5, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL addi_wb: state=%0d regwe=%0b m2r=%0b instret=%0d want 5 1 0 0", state, reg_we, mem_to_reg, instret);
        end
        step();
        checks++;
        if ({state, reg_we, instret} !== {3'd1, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL addi_retire: state=%0d regwe=%0b instret=%0d want 1 0 1", state, reg_we, instret);
        end
    endtask

    task automatic test_load_wait();
        int req_cycles;
        do_reset();
        instr = 32'h00012083; ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, mem_req, ir_we, pc_we} !== {3'd1, 3'b100}) begin
            errors++;
            $display("FAIL fetch_wait: state=%0d req/irwe/pcwe=%b want 1 100", state, {mem_req, ir_we, pc_we});
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        checks++;
        if ({state, alu_src, alu_op, imm_sel} !== {3'd3, 1'b1, 2'd0, 2'd1}) begin
            errors++;
            $display("FAIL load_exec: state=%0d src=%0b op=%0d imm=%0d want 3 1 0 1", state, alu_src, alu_op, imm_sel);
        end
        step();
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (state == 3'd4 && mem_req === 1'b1 && mem_we === 1'b0) req_cycles++;
            if (i == 3) ready = 1'b1;
            if (i < 3) step();
        end
        checks++;
        if (req_cycles !== 4) begin
            errors++;
            $display("FAIL load_mem_hold: got %0d req cycles want 4", req_cycles);
        end
        step();
        ready = 1'b0;
        checks++;
        if ({state, reg_we, mem_to_reg, mem_req} !== {3'd5, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL load_wb: state=%0d regwe=%0b m2r=%0b req=%0b want 5 1 1 0", state, reg_we, mem_to_reg, mem_req);
        end
        step();
        checks++;
        if ({state, instret} !== {3'd1, 32'd1}) begin
            errors++;
            $display("FAIL load_retire: state=%0d instret=%0d want 1 1", state, instret);
        end
    endtask

    task automatic test_back_to_back_beq();
        do_reset();
        instr = 32'h00208463; ready = 1'b1; zero = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({state, imm_sel} !== {3'd2, 2'd3}) begin
            errors++;
            $display("FAIL beq_decode: state=%0d imm=%0d want 2 3", state, imm_sel);
        end
        step();
        checks++;
        if ({state, pc_we, pc_src, alu_src, alu_op, imm_sel, instret} !== {3'd3, 1'b1, 1'b1, 1'b0, 2'd1, 2'd3, 32'd0}) begin
            errors++;
            $display("FAIL beq_taken: state=%0d pcwe=%0b pcsrc=%0b src=%0b op=%0d imm=%0d instret=%0d want 3 1 1 0 1 3 0",
                     state, pc_we, pc_src, alu_src, alu_op, imm_sel, instret);
        end
        step();
        checks++;
        if ({state, instret} !== {3'd1, 32'd1}) begin
            errors++;
            $display("FAIL beq_taken_retire: state=%0d instret=%0d want 1 1", state, instret);
        end
        zero = 1'b0;
        step(); step();
        checks++;
        if ({state, pc_we, pc_src} !== {3'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL beq_not_taken: state=%0d pcwe=%0b pcsrc=%0b want 3 0 1", state, pc_we, pc_src);
        end
        step();
        checks++;
        if ({state, instret} !== {3'd1, 32'd2}) begin
            errors++;
            $display("FAIL beq_nt_retire: state=%0d instret=%0d want 1 2", state, instret);
        end
    endtask

    task automatic test_trap();
        do_reset();
        instr = 32'h00500093; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        instr = 32'h0000007F;
        step();
        checks++;
        if ({state, illegal} !== {3'd2, 1'b0}) begin
            errors++;
            $display("FAIL trap_decode: state=%0d illegal=%0b want 2 0", state, illegal);
        end
        step();
        checks++;
        if ({state, illegal, instret} !== {3'd6, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL trap_enter: state=%0d illegal=%0b instret=%0d want 6 1 1", state, illegal, instret);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({state, illegal, instret, mem_req, ir_we, pc_we, reg_we} !== {3'd6, 1'b1, 32'd1, 4'b0}) begin
            errors++;
            $display("FAIL trap_sticky: state=%0d illegal=%0b instret=%0d strobes=%b want 6 1 1 0000",
                     state, illegal, instret, {mem_req, ir_we, pc_we, reg_we});
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if ({state, illegal, instret} !== {3'd0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL trap_reset: state=%0d illegal=%0b instret=%0d want 0 0 0", state, illegal, instret);
        end
    endtask

    task automatic test_store_reset();
        do_reset();
        instr = 32'h00112023; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (imm_sel !== 2'd2) begin
            errors++;
            $display("FAIL store_decode_imm: got %0d want 2", imm_sel);
        end
        ready = 1'b0;
        step(); step();
        checks++;
        if ({state, mem_req, mem_we} !== {3'd4, 2'b11}) begin
            errors++;
            $display("FAIL store_mem: state=%0d req=%0b we=%0b want 4 1 1", state, mem_req, mem_we);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if ({state, mem_req, mem_we, instret} !== {3'd0, 2'b00, 32'd0}) begin
            errors++;
            $display("FAIL store_abort: state=%0d req=%0b we=%0b instret=%0d want 0 0 0 0", state, mem_req, mem_we, instret);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        checks++;
        if (instret !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h want ffffffff", instret);
        end
        instr = 32'h002081B3; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        checks++;
        if ({state, alu_src, alu_op, imm_sel} !== {3'd3, 1'b0, 2'd2, 2'd0}) begin
            errors++;
            $display("FAIL add_exec: state=%0d src=%0b op=%0d imm=%0d want 3 0 2 0", state, alu_src, alu_op, imm_sel);
        end
        step(); step();
        checks++;
        if ({state, instret} !== {3'd1, 32'd0}) begin
            errors++;
            $display("FAIL wrap_retire: state=%0d instret=%h want 1 00000000", state, instret);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ready = 1'b0; zero = 1'b0; instr = 32'h0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_load_wait();
        test_back_to_back_beq();
        test_trap();
        test_store_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
